// File: rtl/balance_pkg.sv
// Shared types, gains and saturation helpers for the self-balancing PID controller.
package balance_pkg;

    typedef enum logic [1:0] {StOff, StRamp, StRun} bal_state_e;

    localparam int P_COEFF = 12;
    localparam int D_COEFF = 7;

    localparam int unsigned ERR_W   = 10;
    localparam int unsigned DIFF_W  = 7;
    localparam int unsigned INTEG_W = 18;
    localparam int unsigned SPD_W   = 12;

    localparam int ERR_MAX   = 511;
    localparam int ERR_MIN   = -512;
    localparam int DIFF_MAX  = 63;
    localparam int DIFF_MIN  = -64;
    localparam int INTEG_MAX = 131071;
    localparam int INTEG_MIN = -131072;
    localparam int SPD_MAX   = 2047;
    localparam int SPD_MIN   = -2048;

    // Clamp a sign-extended value (any input width up to 32) to out_w signed bits.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                 input int unsigned out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/balance_pid_if.sv
// Sample/command bus between the inertial stage, the PID block and the motor drivers.
interface balance_pid_if;
    logic               vld;
    logic signed [15:0] ptch;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] steer;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;

    modport master (
        output vld, ptch, pwr_up, rider_off, steer,
        input  lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  vld, ptch, pwr_up, rider_off, steer,
        output lft_spd, rght_spd, spd_vld
    );
endinterface

// File: rtl/balance_pid.sv
// Two-stage pipelined PID balance controller with soft-start ramp and differential steering.
module balance_pid
    import balance_pkg::*;
(
    input logic         clk,
    input logic         rst,
    balance_pid_if.slave bus
);

    bal_state_e         state_q, state_d;
    logic [8:0]         ss_tmr_q, ss_tmr_d;
    logic signed [17:0] integ_q, integ_d;
    logic signed [9:0]  err, err_h1_q, err_h2_q;
    logic signed [14:0] p_val, p_q;
    logic signed [11:0] i_val, i_q;
    logic signed [9:0]  d_val, d_q;
    logic               s1_vld_q;
    logic signed [15:0] sum16;
    logic signed [11:0] pid, s_val, lft_val, rght_val;
    logic               out_zero;

    always_comb begin
        state_d  = state_q;
        ss_tmr_d = ss_tmr_q;
        if (!bus.pwr_up) begin
            state_d  = StOff;
            ss_tmr_d = '0;
        end else begin
            case (state_q)
                StOff:  state_d = StRamp;
                StRamp: begin
                    if (bus.vld) begin
                        ss_tmr_d = ss_tmr_q + 9'd1;
                        if (ss_tmr_q == 9'd510) state_d = StRun;
                    end
                end
                StRun:   state_d = StRun;
                default: state_d = StOff;
            endcase
        end
    end

    // Stage 1 terms; I deliberately uses the integrator before this sample is added.
    always_comb begin
        err   = 10'(sat_s(32'(bus.ptch), ERR_W));
        p_val = 15'(32'(err) * P_COEFF);
        i_val = integ_q[17:6];
        d_val = 10'(sat_s(32'(err) - 32'(err_h2_q), DIFF_W) * D_COEFF);
        integ_d = integ_q;
        if (!bus.pwr_up || bus.rider_off) begin
            integ_d = '0;
        end else if (bus.vld && state_q != StOff) begin
            integ_d = 18'(sat_s(32'(integ_q) + 32'(err), INTEG_W));
        end
    end

    always_comb begin
        sum16    = 16'(p_q) + 16'(i_q) + 16'(d_q);
        pid      = 12'(sat_s(32'(sum16), SPD_W));
        out_zero = bus.rider_off || !bus.pwr_up || (state_q == StOff);
        case (state_q)
            StRun:   s_val = pid;
            StRamp:  s_val = 12'((32'(pid) * 32'($signed({1'b0, ss_tmr_q}))) >>> 9);
            default: s_val = '0;
        endcase
        if (out_zero) s_val = '0;
        lft_val  = 12'(sat_s(32'(s_val) + 32'(bus.steer), SPD_W));
        rght_val = 12'(sat_s(32'(s_val) - 32'(bus.steer), SPD_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StOff;
            ss_tmr_q <= '0;
            integ_q  <= '0;
            err_h1_q <= '0;
            err_h2_q <= '0;
        end else begin
            state_q  <= state_d;
            ss_tmr_q <= ss_tmr_d;
            integ_q  <= integ_d;
            if (!bus.pwr_up) begin
                err_h1_q <= '0;
                err_h2_q <= '0;
            end else if (bus.vld) begin
                err_h1_q <= err;
                err_h2_q <= err_h1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            p_q          <= '0;
            i_q          <= '0;
            d_q          <= '0;
            bus.spd_vld  <= 1'b0;
            bus.lft_spd  <= '0;
            bus.rght_spd <= '0;
        end else begin
            s1_vld_q    <= bus.vld;
            bus.spd_vld <= s1_vld_q;
            if (bus.vld) begin
                p_q <= p_val;
                i_q <= i_val;
                d_q <= d_val;
            end
            // Zeroing is level-driven so outputs drop even with no sample in flight.
            if (out_zero) begin
                bus.lft_spd  <= '0;
                bus.rght_spd <= '0;
            end else if (s1_vld_q) begin
                bus.lft_spd  <= lft_val;
                bus.rght_spd <= rght_val;
            end
        end
    end

endmodule

// File: tb/tb_balance_pid.sv
// Randomised and directed bench for balance_pid against a behavioural cycle model.
module tb_balance_pid;
    import balance_pkg::*;

    logic clk = 1'b0;
    logic rst;

    balance_pid_if bus ();

    balance_pid dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: 0 = off, 1 = ramp, 2 = run
    int m_st, m_ss, m_integ, m_h1, m_h2, m_dv, m_dsum, m_lft, m_rght, m_sv;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic tick();
        int err, pid, s, p, st;
        int n_st, n_ss, n_integ, n_h1, n_h2, n_dv, n_dsum, n_lft, n_rght, n_sv;
        n_st = m_st; n_ss = m_ss; n_integ = m_integ; n_h1 = m_h1; n_h2 = m_h2;
        n_dv = m_dv; n_dsum = m_dsum; n_lft = m_lft; n_rght = m_rght; n_sv = m_sv;
        p  = bus.ptch;
        st = bus.steer;
        if (rst) begin
            n_st = 0; n_ss = 0; n_integ = 0; n_h1 = 0; n_h2 = 0;
            n_dv = 0; n_dsum = 0; n_lft = 0; n_rght = 0; n_sv = 0;
        end else begin
            n_sv = m_dv;
            if (!bus.pwr_up || bus.rider_off || m_st == 0) begin
                n_lft = 0;
                n_rght = 0;
            end else if (m_dv != 0) begin
                pid    = clampi(m_dsum, SPD_MIN, SPD_MAX);
                s      = (m_st == 2) ? pid : ((pid * m_ss) >>> 9);
                n_lft  = clampi(s + st, SPD_MIN, SPD_MAX);
                n_rght = clampi(s - st, SPD_MIN, SPD_MAX);
            end
            err  = clampi(p, ERR_MIN, ERR_MAX);
            n_dv = int'(bus.vld);
            if (bus.vld)
                n_dsum = err * P_COEFF + (m_integ >>> 6)
                       + clampi(err - m_h2, DIFF_MIN, DIFF_MAX) * D_COEFF;
            if (!bus.pwr_up || bus.rider_off) n_integ = 0;
            else if (bus.vld && m_st != 0)
                n_integ = clampi(m_integ + err, INTEG_MIN, INTEG_MAX);
            if (!bus.pwr_up) begin
                n_h1 = 0; n_h2 = 0;
            end else if (bus.vld) begin
                n_h2 = m_h1; n_h1 = err;
            end
            if (!bus.pwr_up) begin
                n_st = 0; n_ss = 0;
            end else if (m_st == 0) begin
                n_st = 1;
            end else if (m_st == 1 && bus.vld) begin
                n_ss = m_ss + 1;
                if (n_ss == 511) n_st = 2;
            end
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_ss = n_ss; m_integ = n_integ; m_h1 = n_h1; m_h2 = n_h2;
        m_dv = n_dv; m_dsum = n_dsum; m_lft = n_lft; m_rght = n_rght; m_sv = n_sv;
        check_val("lft_spd", bus.lft_spd, m_lft);
        check_val("rght_spd", bus.rght_spd, m_rght);
        check_val("spd_vld", bus.spd_vld, m_sv);
    endtask

    task automatic send(input logic [15:0] p);
        bus.ptch = p;
        bus.vld  = 1'b1;
        tick();
        bus.vld  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.vld = 1'b0; bus.ptch = '0; bus.pwr_up = 1'b0;
        bus.rider_off = 1'b0; bus.steer = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("reset_state", dut.state_q, StOff);
        check_val("reset_integ", dut.integ_q, 0);
        check_val("reset_lft", bus.lft_spd, 0);

        // Soft-start ramp
        bus.pwr_up = 1'b1;
        tick();
        repeat (254) send(16'd0);
        send(16'd16);
        send(16'd16);
        send(16'd16);
        tick();
        check_val("ramp_half_lft", bus.lft_spd, 96);
        check_val("ramp_half_rght", bus.rght_spd, 96);
        repeat (253) send(16'd0);
        check_val("ramp_510", dut.state_q, StRamp);
        send(16'd0);
        check_val("ramp_to_run", dut.state_q, StRun);

        bus.rider_off = 1'b1;
        tick();
        bus.rider_off = 1'b0;
        check_val("integ_cleared", dut.integ_q, 0);

        // Derivative history walk in RUN
        send(16'd16); tick();
        check_val("run_pd1", bus.lft_spd, 304);
        check_val("run_pd1_r", bus.rght_spd, 304);
        send(16'd16); tick();
        check_val("run_pd2", bus.lft_spd, 304);
        send(16'd16); tick();
        check_val("run_p_only", bus.lft_spd, 192);
        bus.steer = 12'sd100;
        send(16'd16); tick();
        check_val("steer_lft", bus.lft_spd, 292);
        check_val("steer_rght", bus.rght_spd, 92);
        bus.steer = '0;

        send(16'h8000); tick();
        check_val("sat_neg_lft", bus.lft_spd, -2048);
        check_val("sat_neg_rght", bus.rght_spd, -2048);
        send(16'h7fff); tick();
        check_val("sat_pos_lft", bus.lft_spd, 2047);
        check_val("sat_pos_rght", bus.rght_spd, 2047);

        repeat (300) send(16'd511);
        tick();
        check_val("integ_clamp", dut.integ_q, INTEG_MAX);
        check_val("integ_clamp_out", bus.lft_spd, 2047);
        send(16'd511); tick();
        check_val("integ_no_wrap", dut.integ_q, INTEG_MAX);

        bus.rider_off = 1'b1;
        tick(); tick();
        check_val("rider_off_lft", bus.lft_spd, 0);
        check_val("rider_off_rght", bus.rght_spd, 0);
        check_val("rider_off_integ", dut.integ_q, 0);
        check_val("rider_off_state", dut.state_q, StRun);
        bus.rider_off = 1'b0;

        bus.pwr_up = 1'b0;
        tick();
        check_val("pwr_down_state", dut.state_q, StOff);
        check_val("pwr_down_lft", bus.lft_spd, 0);

        // Reset with a sample in flight
        bus.pwr_up = 1'b1;
        tick();
        send(16'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_drop", bus.spd_vld, 0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.vld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.ptch = 16'($urandom);
            else bus.ptch = 16'($urandom_range(0, 400) - 200);
            bus.steer     = 12'($urandom_range(0, 600) - 300);
            bus.rider_off = ($urandom_range(0, 63) == 0);
            bus.pwr_up    = ($urandom_range(0, 1499) != 0);
            rst           = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        bus.vld = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
